// File: rtl/bt_pkg.sv
// Shared width, word type and ALU opcode encodings for the bt datapath slices.
package bt_pkg;

  localparam int BT_WIDTH = 64;

  typedef logic [BT_WIDTH-1:0] bt_word_t;

  // Opcodes decoded by the ALU result mux that sits above this slice.
  localparam logic [2:0] PASS_B = 3'b000;
  localparam logic [2:0] ADD    = 3'b001;
  localparam logic [2:0] SUB    = 3'b010;
  localparam logic [2:0] AND    = 3'b011;
  localparam logic [2:0] OR     = 3'b100;
  localparam logic [2:0] XOR    = 3'b101;

endpackage

// File: rtl/bt_full_adder_bit.sv
// One-bit full adder cell used to build the ripple-carry chain.
// Purely combinational; no latency, no flow control.
module bt_full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/bt_64_add_logic_unit.sv
// Registered add/sub + AND/OR slice (xor_result added when BT_XOR_OUT_EN is defined).
// Latency 1 cycle; no backpressure, accepts in_valid every cycle.
module bt_64_add_logic_unit
  import bt_pkg::*;
#(
  parameter int WIDTH = BT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic [WIDTH-1:0] and_result,
  output logic [WIDTH-1:0] or_result
`ifdef BT_XOR_OUT_EN
  ,
  output logic [WIDTH-1:0] xor_result
`endif
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum_comb;
  logic [WIDTH:0]   c;

  // Subtraction is A + ~B + 1, with the +1 entering as carry-in.
  assign b_eff = sub ? ~b : b;
  assign c[0]  = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    bt_full_adder_bit u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (c[i]),
      .s    (sum_comb[i]),
      .cout (c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      overflow   <= 1'b0;
      and_result <= '0;
      or_result  <= '0;
`ifdef BT_XOR_OUT_EN
      xor_result <= '0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum        <= sum_comb;
        cout       <= c[WIDTH];
        overflow   <= c[WIDTH] ^ c[WIDTH-1];
        and_result <= a & b;
        or_result  <= a | b;
`ifdef BT_XOR_OUT_EN
        xor_result <= a ^ b;
`endif
      end
    end
  end

endmodule

// File: tb/tb_bt_64_add_logic_unit.sv
// Randomised and directed bench for bt_64_add_logic_unit against an arithmetic reference model.
module tb_bt_64_add_logic_unit;
  import bt_pkg::*;

  logic     clk;
  logic     reset;
  logic     in_valid;
  bt_word_t a;
  bt_word_t b;
  logic     sub;
  logic     out_valid;
  bt_word_t sum;
  logic     cout;
  logic     overflow;
  bt_word_t and_result;
  bt_word_t or_result;
`ifdef BT_XOR_OUT_EN
  bt_word_t xor_result;
`endif

  bt_64_add_logic_unit #(.WIDTH(BT_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .sub        (sub),
    .out_valid  (out_valid),
    .sum        (sum),
    .cout       (cout),
    .overflow   (overflow),
    .and_result (and_result),
    .or_result  (or_result)
`ifdef BT_XOR_OUT_EN
    ,
    .xor_result (xor_result)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected registered state of the unit.
  logic     exp_valid;
  bt_word_t exp_sum;
  logic     exp_cout;
  logic     exp_ov;
  bt_word_t exp_and;
  bt_word_t exp_or;
  bt_word_t exp_xor;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Applies one cycle of inputs, advances the model by one clock edge, then checks every output.
  task automatic step(input string tag, input logic r, input logic v, input logic s,
                      input logic [63:0] x, input logic [63:0] y);
    logic [64:0] full;
    logic [63:0] be;
    reset = r; in_valid = v; sub = s; a = x; b = y;
    @(posedge clk);
    if (r) begin
      exp_valid = 1'b0; exp_sum = '0; exp_cout = 1'b0; exp_ov = 1'b0;
      exp_and = '0; exp_or = '0; exp_xor = '0;
    end else begin
      exp_valid = v;
      if (v) begin
        be       = s ? ~y : y;
        full     = {1'b0, x} + {1'b0, be} + 65'(s);
        exp_sum  = full[63:0];
        exp_cout = full[64];
        exp_ov   = (x[63] == be[63]) && (full[63] != x[63]);
        exp_and  = x & y;
        exp_or   = x | y;
        exp_xor  = x ^ y;
      end
    end
    @(negedge clk);
    check({tag, ".valid"}, 64'(out_valid), 64'(exp_valid));
    check({tag, ".sum"},   sum, exp_sum);
    check({tag, ".cout"},  64'(cout), 64'(exp_cout));
    check({tag, ".ovf"},   64'(overflow), 64'(exp_ov));
    check({tag, ".and"},   and_result, exp_and);
    check({tag, ".or"},    or_result, exp_or);
`ifdef BT_XOR_OUT_EN
    check({tag, ".xor"},   xor_result, exp_xor);
`endif
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    case ($urandom_range(0, 5))
      0:       w = 64'h7FFF_FFFF_FFFF_FFFF;
      1:       w = 64'h8000_0000_0000_0000;
      2:       w = '1;
      3:       w = 64'(($urandom_range(0, 3)));
      default: w = {$urandom, $urandom};
    endcase
    return w;
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0;
    exp_valid = 1'b0; exp_sum = '0; exp_cout = 1'b0; exp_ov = 1'b0;
    exp_and = '0; exp_or = '0; exp_xor = '0;
    @(negedge clk);

    // Reset held two cycles with in_valid asserted must dominate.
    step("rst0", 1'b1, 1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h1234);
    step("rst1", 1'b1, 1'b1, 1'b1, 64'h5555, 64'hAAAA);
    check("rst_valid_zero", 64'(out_valid), 64'h0);
    check("rst_sum_zero", sum, 64'h0);

    step("add1", 1'b0, 1'b1, 1'b0, 64'h1, 64'h1);
    check("add1_sum_const", sum, 64'h2);
    step("addff", 1'b0, 1'b1, 1'b0, '1, '1);
    check("addff_sum_const", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check("addff_cout_const", 64'(cout), 64'h1);
    step("sovf", 1'b0, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    check("sovf_sum_const", sum, 64'h8000_0000_0000_0000);
    check("sovf_ovf_const", 64'(overflow), 64'h1);
    step("sub1", 1'b0, 1'b1, 1'b1, 64'h0001_0001_0001_0100, 64'h0010_0100_0000_0001);
    check("sub1_sum_const", sum, 64'hFFF0_FF01_0001_00FF);
    check("sub1_cout_const", 64'(cout), 64'h0);
    check("logic1_and_const", and_result, 64'h0);
    step("logic2", 1'b0, 1'b1, 1'b0, 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111);
    check("logic2_and_const", and_result, 64'h1111_1111_1111_1111);
    check("logic2_or_const", or_result, 64'h1111_1111_1111_1111);
    step("logic3", 1'b0, 1'b1, 1'b1, 64'h1, 64'h1111_1111_1111_1111);
    check("logic3_or_const", or_result, 64'h1111_1111_1111_1111);
`ifdef BT_XOR_OUT_EN
    step("xor1", 1'b0, 1'b1, 1'b0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0);
    check("xor1_const", xor_result, 64'hF0F0_F0F0_F0F0_F0F0);
`endif

    // Alternating in_valid: idle cycles must hold results and drop out_valid.
    for (int i = 0; i < 8; i++) begin
      step("alt", 1'b0, i[0] == 1'b0, i[1], rand_word(), rand_word());
      check("alt_valid_const", 64'(out_valid), 64'(i[0] == 1'b0));
    end

    // Reset mid-stream discards the captured result.
    step("pre_rst", 1'b0, 1'b1, 1'b0, 64'h10, 64'h20);
    step("mid_rst", 1'b1, 1'b1, 1'b0, 64'h30, 64'h40);
    step("post_rst", 1'b0, 1'b0, 1'b0, 64'h50, 64'h60);
    check("post_rst_sum_const", sum, 64'h0);

    for (int i = 0; i < 300; i++) begin
      step("rand", $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), rand_word(), rand_word());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
